player_anim_sequencer: RTL and testbench

- Parametrised successor to the per-player animation arbiter.
- Resolves hitstun, lose, attack, jump and move requests into one animation state plus frame index, one per player.
- Adds internally timed frame sequences for walk, hit and lose, and a generalised attack-type-to-state map.
- Adds a state-change pulse and a lose-sequence-complete flag.
- Sits between the resolver/attack/move modules and the sprite renderer.

---
 rtl/player_anim_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_player_anim_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_anim_sequencer.sv
// player_anim_sequencer: per-player animation state/frame sequencer.
// Resolves lose/hitstun/attack/jump/move requests into one registered
// animation state and frame index. Walk, hit and lose frames are timed
// internally; attack and jump frames pass through from their sources.
// Optional build macro: IDLE_BREATH_EN (internally timed idle cycle).
module player_anim_sequencer #(
  parameter int FRAME_W     = 6,
  parameter int N_ATK       = 4,
  parameter int ATK_W       = 2,
  parameter int FRAME_HOLD  = 4,
  parameter int WALK_FRAMES = 8,
  parameter int HIT_FRAMES  = 4,
  parameter int LOSE_FRAMES = 6,
  parameter int IDLE_FRAMES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               SCEN,
  input  logic               lose_active,
  input  logic               hitstun_active,
  input  logic               attack_active,
  input  logic [ATK_W-1:0]   attack_type,
  input  logic [FRAME_W-1:0] attack_frame,
  input  logic               jump_active,
  input  logic [FRAME_W-1:0] jump_frame,
  input  logic               move_active,
  output logic [3:0]         anim_state,
  output logic [FRAME_W-1:0] anim_frame,
  output logic               anim_new,
  output logic               anim_done
);

  // Hold counter must be able to hold FRAME_HOLD-1; never narrower than 1 bit.
  localparam int HOLD_W = $clog2(FRAME_HOLD + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(FRAME_HOLD - 1);
  localparam logic [FRAME_W-1:0] WALK_LAST = FRAME_W'(WALK_FRAMES - 1);
  localparam logic [FRAME_W-1:0] HIT_LAST  = FRAME_W'(HIT_FRAMES - 1);
  localparam logic [FRAME_W-1:0] LOSE_LAST = FRAME_W'(LOSE_FRAMES - 1);
`ifdef IDLE_BREATH_EN
  localparam logic [FRAME_W-1:0] IDLE_LAST = FRAME_W'(IDLE_FRAMES - 1);
`endif

  // Parameter legality, caught at elaboration.
  generate
    if (N_ATK < 1 || N_ATK > 8) begin : g_bad_n_atk
      $error("player_anim_sequencer: N_ATK must be in 1..8");
    end
    if (FRAME_HOLD < 1) begin : g_bad_hold
      $error("player_anim_sequencer: FRAME_HOLD must be >= 1");
    end
    if (WALK_FRAMES < 1 || WALK_FRAMES > (32'd1 << FRAME_W)) begin : g_bad_walk
      $error("player_anim_sequencer: WALK_FRAMES out of range for FRAME_W");
    end
    if (HIT_FRAMES < 1 || HIT_FRAMES > (32'd1 << FRAME_W)) begin : g_bad_hit
      $error("player_anim_sequencer: HIT_FRAMES out of range for FRAME_W");
    end
    if (LOSE_FRAMES < 1 || LOSE_FRAMES > (32'd1 << FRAME_W)) begin : g_bad_lose
      $error("player_anim_sequencer: LOSE_FRAMES out of range for FRAME_W");
    end
    if (IDLE_FRAMES < 1 || IDLE_FRAMES > (32'd1 << FRAME_W)) begin : g_bad_idle
      $error("player_anim_sequencer: IDLE_FRAMES out of range for FRAME_W");
    end
  endgenerate

  // State categories; ATK is the base code, the attack index is added on top.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_WALK = 4'd1,
    ST_JUMP = 4'd2,
    ST_HIT  = 4'd3,
    ST_LOSE = 4'd4,
    ST_ATK  = 4'd8
  } state_t;

  logic [3:0]         r_anim_state;
  logic [FRAME_W-1:0] r_anim_frame;
  logic               r_anim_new;
  logic               r_anim_done;
  logic               r_lose;
  logic [HOLD_W-1:0]  r_hold;
  logic [FRAME_W-1:0] r_cnt;

  state_t             w_state_nxt;
  logic [3:0]         w_atk_code;
  logic [3:0]         w_code_nxt;
  logic               w_entry;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [FRAME_W-1:0] w_cnt_nxt;
  logic [FRAME_W-1:0] w_frame_nxt;
  logic               w_done_nxt;

  // Attack code with out-of-range attack types clamped to the last attack.
  assign w_atk_code = (32'(attack_type) >= 32'(N_ATK))
                    ? 4'(32'd8 + 32'(N_ATK) - 32'd1)
                    : 4'(32'd8 + 32'(attack_type));

  // Priority resolution: LOSE (latched) > HIT > ATK > JUMP > WALK > IDLE.
  always_comb begin
    w_state_nxt = ST_IDLE;
    if (r_lose || lose_active) begin
      w_state_nxt = ST_LOSE;
    end else if (hitstun_active) begin
      w_state_nxt = ST_HIT;
    end else if (attack_active) begin
      w_state_nxt = ST_ATK;
    end else if (jump_active) begin
      w_state_nxt = ST_JUMP;
    end else if (move_active) begin
      w_state_nxt = ST_WALK;
    end else begin
      w_state_nxt = ST_IDLE;
    end
  end

  assign w_code_nxt = (w_state_nxt == ST_ATK) ? w_atk_code : w_state_nxt;
  // Any change of code, including ATK(k) to ATK(j), restarts the sequence.
  assign w_entry    = (w_code_nxt != r_anim_state);

  // Internal hold/frame counter: restart on entry, advance every FRAME_HOLD ticks.
  always_comb begin
    w_hold_nxt = r_hold;
    w_cnt_nxt  = r_cnt;
    if (w_entry) begin
      w_hold_nxt = {HOLD_W{1'b0}};
      w_cnt_nxt  = {FRAME_W{1'b0}};
    end else if (r_hold == HOLD_LAST) begin
      w_hold_nxt = {HOLD_W{1'b0}};
      case (w_state_nxt)
        ST_WALK: w_cnt_nxt = (r_cnt == WALK_LAST) ? {FRAME_W{1'b0}} : r_cnt + FRAME_W'(1);
        ST_HIT:  w_cnt_nxt = (r_cnt == HIT_LAST)  ? r_cnt : r_cnt + FRAME_W'(1);
        ST_LOSE: w_cnt_nxt = (r_cnt == LOSE_LAST) ? r_cnt : r_cnt + FRAME_W'(1);
`ifdef IDLE_BREATH_EN
        ST_IDLE: w_cnt_nxt = (r_cnt == IDLE_LAST) ? {FRAME_W{1'b0}} : r_cnt + FRAME_W'(1);
`endif
        default: w_cnt_nxt = r_cnt;
      endcase
    end else begin
      w_hold_nxt = r_hold + HOLD_W'(1);
      w_cnt_nxt  = r_cnt;
    end
  end

  // Frame source selection for the state being entered or held.
  always_comb begin
    w_frame_nxt = {FRAME_W{1'b0}};
    case (w_state_nxt)
      ST_ATK:  w_frame_nxt = attack_frame;
      ST_JUMP: w_frame_nxt = jump_frame;
      ST_WALK: w_frame_nxt = w_cnt_nxt;
      ST_HIT:  w_frame_nxt = w_cnt_nxt;
      ST_LOSE: w_frame_nxt = w_cnt_nxt;
`ifdef IDLE_BREATH_EN
      ST_IDLE: w_frame_nxt = w_cnt_nxt;
`else
      ST_IDLE: w_frame_nxt = {FRAME_W{1'b0}};
`endif
      default: w_frame_nxt = {FRAME_W{1'b0}};
    endcase
  end

  // Done is sticky once the lose sequence reaches its last frame.
  assign w_done_nxt = r_anim_done
                    | ((w_state_nxt == ST_LOSE) && (w_cnt_nxt == LOSE_LAST));

  // State register and registered outputs; only SCEN ticks advance, anim_new self-clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_anim_state <= 4'd0;
      r_anim_frame <= {FRAME_W{1'b0}};
      r_anim_new   <= 1'b0;
      r_anim_done  <= 1'b0;
      r_lose       <= 1'b0;
      r_hold       <= {HOLD_W{1'b0}};
      r_cnt        <= {FRAME_W{1'b0}};
    end else if (SCEN) begin
      r_anim_state <= w_code_nxt;
      r_anim_frame <= w_frame_nxt;
      r_anim_new   <= w_entry;
      r_anim_done  <= w_done_nxt;
      r_lose       <= r_lose | lose_active;
      r_hold       <= w_hold_nxt;
      r_cnt        <= w_cnt_nxt;
    end else begin
      r_anim_new   <= 1'b0;
    end
  end

  assign anim_state = r_anim_state;
  assign anim_frame = r_anim_frame;
  assign anim_new   = r_anim_new;
  assign anim_done  = r_anim_done;

endmodule

// File: tb/tb_player_anim_sequencer.sv
// Self-checking bench for player_anim_sequencer: directed scenarios plus
// randomized traffic, all compared against a tick-count reference model.
module tb_player_anim_sequencer;

  localparam int FRAME_W = 6;
  localparam int N_ATK   = 3;
  localparam int ATK_W   = 2;
  localparam int FH      = 4;
  localparam int WF      = 8;
  localparam int HF      = 4;
  localparam int LF      = 6;
  localparam int IDF     = 4;

  logic               clk = 1'b0;
  logic               reset, SCEN;
  logic               lose_active, hitstun_active, attack_active, jump_active, move_active;
  logic [ATK_W-1:0]   attack_type;
  logic [FRAME_W-1:0] attack_frame, jump_frame;
  logic [3:0]         anim_state;
  logic [FRAME_W-1:0] anim_frame;
  logic               anim_new, anim_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: state code, ticks since entry, sticky flags.
  logic [3:0]         m_state;
  logic [FRAME_W-1:0] m_frame;
  logic               m_new, m_done, m_lose;
  int                 m_ticks;

  always #5 clk = ~clk;

  player_anim_sequencer #(
    .FRAME_W(FRAME_W), .N_ATK(N_ATK), .ATK_W(ATK_W), .FRAME_HOLD(FH),
    .WALK_FRAMES(WF), .HIT_FRAMES(HF), .LOSE_FRAMES(LF), .IDLE_FRAMES(IDF)
  ) dut (
    .clk(clk), .reset(reset), .SCEN(SCEN),
    .lose_active(lose_active), .hitstun_active(hitstun_active),
    .attack_active(attack_active), .attack_type(attack_type), .attack_frame(attack_frame),
    .jump_active(jump_active), .jump_frame(jump_frame), .move_active(move_active),
    .anim_state(anim_state), .anim_frame(anim_frame), .anim_new(anim_new), .anim_done(anim_done)
  );

  task automatic clear_inputs();
    reset = 1'b0; SCEN = 1'b1;
    lose_active = 1'b0; hitstun_active = 1'b0; attack_active = 1'b0;
    jump_active = 1'b0; move_active = 1'b0;
    attack_type = '0; attack_frame = '0; jump_frame = '0;
  endtask

  // Frame n of a timed sequence is shown from tick n*FH after entry.
  task automatic model_step();
    int want;
    int f;
    if (reset) begin
      m_state = 4'd0; m_frame = '0; m_new = 1'b0; m_done = 1'b0; m_lose = 1'b0; m_ticks = 0;
    end else if (SCEN) begin
      if (lose_active) m_lose = 1'b1;
      if (m_lose) want = 4;
      else if (hitstun_active) want = 3;
      else if (attack_active)
        want = 8 + ((int'(attack_type) >= N_ATK) ? N_ATK - 1 : int'(attack_type));
      else if (jump_active) want = 2;
      else if (move_active) want = 1;
      else want = 0;
      m_new   = (want != int'(m_state));
      m_ticks = m_new ? 0 : m_ticks + 1;
      m_state = 4'(want);
      case (want)
        0: begin
`ifdef IDLE_BREATH_EN
          f = (m_ticks / FH) % IDF;
`else
          f = 0;
`endif
        end
        1: f = (m_ticks / FH) % WF;
        2: f = int'(jump_frame);
        3: f = (m_ticks / FH < HF - 1) ? m_ticks / FH : HF - 1;
        4: f = (m_ticks / FH < LF - 1) ? m_ticks / FH : LF - 1;
        default: f = int'(attack_frame);
      endcase
      m_frame = FRAME_W'(f);
      if (want == 4 && f == LF - 1) m_done = 1'b1;
    end else begin
      m_new = 1'b0;
    end
  endtask

  // Advance the model with the current inputs, then let the DUT see the same edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1; lose_active = 1'b1; hitstun_active = 1'b1; attack_active = 1'b1;
    jump_active = 1'b1; move_active = 1'b1; attack_type = 2'd3;
    attack_frame = 6'd7; jump_frame = 6'd9;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_tests++;
      if (anim_state !== 4'd0 || anim_frame !== 6'd0 || anim_new !== 1'b0 || anim_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset: got st=%0d fr=%0d new=%b done=%b, want 0 0 0 0",
                 anim_state, anim_frame, anim_new, anim_done);
      end
    end
    clear_inputs();
    move_active = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_tests++;
      if (anim_state !== 4'd1 || anim_new !== (i == 0) || anim_state !== m_state ||
          anim_frame !== m_frame || anim_done !== m_done) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: got st=%0d fr=%0d new=%b done=%b, want st=1 fr=%0d new=%b done=%b",
                 i, anim_state, anim_frame, anim_new, anim_done, m_frame, (i == 0), m_done);
      end
    end
  endtask

  task automatic test_walk_wrap();
    int pulses = 0;
    clear_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0; move_active = 1'b1;
    for (int i = 0; i < 120; i++) begin
      SCEN = (i % 3 == 0);
      cycle();
      if (anim_new) pulses++;
      n_tests++;
      if (anim_state !== m_state || anim_frame !== m_frame || anim_new !== m_new || anim_done !== m_done) begin
        n_fail++;
        $display("FAIL walk[%0d]: got st=%0d fr=%0d new=%b done=%b, want st=%0d fr=%0d new=%b done=%b",
                 i, anim_state, anim_frame, anim_new, anim_done, m_state, m_frame, m_new, m_done);
      end
    end
    n_tests++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL walk_pulses: got %0d, want 1", pulses);
    end
  endtask

  task automatic test_priority();
    clear_inputs();
    attack_active = 1'b1; attack_type = 2'd1; attack_frame = 6'd5;
    jump_active = 1'b1; jump_frame = 6'd33; move_active = 1'b1;
    cycle();
    n_tests++;
    if (anim_state !== 4'd9 || anim_frame !== 6'd5 || anim_state !== m_state || anim_new !== m_new) begin
      n_fail++;
      $display("FAIL prio_atk: got st=%0d fr=%0d new=%b, want st=9 fr=5 new=%b", anim_state, anim_frame, anim_new, m_new);
    end
    hitstun_active = 1'b1;
    cycle();
    n_tests++;
    if (anim_state !== 4'd3 || anim_frame !== 6'd0 || anim_new !== 1'b1 || anim_state !== m_state) begin
      n_fail++;
      $display("FAIL prio_hit: got st=%0d fr=%0d new=%b, want st=3 fr=0 new=1", anim_state, anim_frame, anim_new);
    end
    hitstun_active = 1'b0;
    cycle();
    n_tests++;
    if (anim_state !== 4'd9 || anim_frame !== 6'd5 || anim_new !== 1'b1 || anim_new !== m_new) begin
      n_fail++;
      $display("FAIL prio_back: got st=%0d fr=%0d new=%b, want st=9 fr=5 new=1", anim_state, anim_frame, anim_new);
    end
    cycle();
    n_tests++;
    if (anim_new !== 1'b0 || anim_state !== m_state) begin
      n_fail++;
      $display("FAIL prio_pulse_width: got new=%b st=%0d, want new=0 st=%0d", anim_new, anim_state, m_state);
    end
  endtask

  task automatic test_attack_clamp();
    logic [3:0] want_st [3];
    logic       want_new [3];
    logic [1:0] types [3];
    types[0] = 2'd3; types[1] = 2'd0; types[2] = 2'd1;
    want_st[0] = 4'd10; want_st[1] = 4'd8; want_st[2] = 4'd9;
    want_new[0] = 1'b1; want_new[1] = 1'b1; want_new[2] = 1'b1;
    clear_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0; attack_active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      attack_type = types[i];
      attack_frame = FRAME_W'($urandom_range(0, 63));
      cycle();
      n_tests++;
      if (anim_state !== want_st[i] || anim_new !== want_new[i] || anim_frame !== attack_frame ||
          anim_state !== m_state) begin
        n_fail++;
        $display("FAIL clamp[%0d]: got st=%0d new=%b fr=%0d, want st=%0d new=%b fr=%0d",
                 i, anim_state, anim_new, anim_frame, want_st[i], want_new[i], attack_frame);
      end
    end
  endtask

  task automatic test_hit_saturation();
    clear_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0; hitstun_active = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cycle();
      n_tests++;
      if (anim_state !== m_state || anim_frame !== m_frame || anim_new !== m_new || anim_done !== m_done) begin
        n_fail++;
        $display("FAIL hit[%0d]: got st=%0d fr=%0d new=%b done=%b, want st=%0d fr=%0d new=%b done=%b",
                 i, anim_state, anim_frame, anim_new, anim_done, m_state, m_frame, m_new, m_done);
      end
    end
    n_tests++;
    if (anim_frame !== 6'(HF - 1)) begin
      n_fail++;
      $display("FAIL hit_sat: got fr=%0d, want %0d", anim_frame, HF - 1);
    end
  endtask

  task automatic test_lose_sticky();
    int first_done = -1;
    clear_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0; lose_active = 1'b1;
    cycle();
    lose_active = 1'b0; attack_active = 1'b1; attack_type = 2'd2;
    for (int i = 1; i <= 30; i++) begin
      SCEN = (i % 7 != 0) || (i > 25);
      cycle();
      if (anim_done && first_done < 0) first_done = i;
      n_tests++;
      if (anim_state !== 4'd4 || anim_frame !== m_frame || anim_new !== m_new || anim_done !== m_done) begin
        n_fail++;
        $display("FAIL lose[%0d]: got st=%0d fr=%0d new=%b done=%b, want st=4 fr=%0d new=%b done=%b",
                 i, anim_state, anim_frame, anim_new, anim_done, m_frame, m_new, m_done);
      end
    end
    n_tests++;
    if (anim_done !== 1'b1 || anim_frame !== 6'(LF - 1)) begin
      n_fail++;
      $display("FAIL lose_done: got done=%b fr=%0d (first at clk %0d), want done=1 fr=%0d",
               anim_done, anim_frame, first_done, LF - 1);
    end
    reset = 1'b1;
    cycle();
    n_tests++;
    if (anim_state !== 4'd0 || anim_done !== 1'b0 || anim_frame !== 6'd0 || anim_new !== 1'b0) begin
      n_fail++;
      $display("FAIL lose_reset: got st=%0d done=%b fr=%0d new=%b, want 0 0 0 0",
               anim_state, anim_done, anim_frame, anim_new);
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    clear_inputs();
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 299) == 0);
      SCEN           = ($urandom_range(0, 3) != 0);
      lose_active    = ($urandom_range(0, 399) == 0);
      hitstun_active = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) attack_active = ~attack_active;
      if ($urandom_range(0, 15) == 0) attack_type = ATK_W'($urandom_range(0, 3));
      attack_frame   = FRAME_W'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) jump_active = ~jump_active;
      jump_frame     = FRAME_W'($urandom_range(0, 63));
      if ($urandom_range(0, 5) == 0) move_active = ~move_active;
      cycle();
      n_tests++;
      if (anim_state !== m_state || anim_frame !== m_frame || anim_new !== m_new || anim_done !== m_done) begin
        n_fail++;
        $display("FAIL random[%0d]: got st=%0d fr=%0d new=%b done=%b, want st=%0d fr=%0d new=%b done=%b",
                 i, anim_state, anim_frame, anim_new, anim_done, m_state, m_frame, m_new, m_done);
      end
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    m_state = 4'd0; m_frame = '0; m_new = 1'b0; m_done = 1'b0; m_lose = 1'b0; m_ticks = 0;
    test_reset();
    test_walk_wrap();
    test_priority();
    test_attack_clamp();
    test_hit_saturation();
    test_lose_sticky();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
